// File: rtl/pipe_control.sv
// ---------------------------------------------------------------------------
// pipe_control - control unit for the 5-stage (F/D/E/M/W) MIPS pipeline.
//
// Decodes the D-stage instruction, carries the control bundle through the
// E, M and W control registers, raises the Tuse/Tnew stall, and drives the
// operand forwarding selects for the D, E and M stages.
//
// Ports
//   clk        in   core clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   instr_d    in   [31:0] instruction in the IF/ID register
//   stall      out  freeze PC and IF/ID, bubble into E
//   branch_d   out  [1:0] 00 none, 01 beq, 10 j/jal, 11 jr
//   extop_d    out  [1:0] 00 sign, 01 zero, 10 lui
//   aluctrl_e  out  [2:0] 000 add, 001 sub, 010 or
//   alusrc_e   out  ALU operand B is the immediate
//   memwrite_m out  data-memory write enable
//   regwrite_w out  register-file write enable
//   wsel_w     out  [1:0] 00 ALU, 01 memory, 10 PC+8, 11 extended immediate
//   a3_e/m/w   out  [REG_AW-1:0] destination register per stage (0 = none)
//   fwd_rs_d   out  [1:0] 00 RF, 01 E(PC+8), 10 M, 11 W
//   fwd_rt_d   out  [1:0] same encoding as fwd_rs_d
//   fwd_rs_e   out  [1:0] 00 ID/EX, 10 M, 11 W
//   fwd_rt_e   out  [1:0] same encoding as fwd_rs_e
//   fwd_rt_m   out  sw store data from the W result
// ---------------------------------------------------------------------------
module pipe_control #(
    parameter int REG_AW    = 5,
    parameter int LINK_REG  = 31,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       instr_d,
    output logic              stall,
    output logic [1:0]        branch_d,
    output logic [1:0]        extop_d,
    output logic [2:0]        aluctrl_e,
    output logic              alusrc_e,
    output logic              memwrite_m,
    output logic              regwrite_w,
    output logic [1:0]        wsel_w,
    output logic [REG_AW-1:0] a3_e,
    output logic [REG_AW-1:0] a3_m,
    output logic [REG_AW-1:0] a3_w,
    output logic [1:0]        fwd_rs_d,
    output logic [1:0]        fwd_rt_d,
    output logic [1:0]        fwd_rs_e,
    output logic [1:0]        fwd_rt_e,
    output logic              fwd_rt_m
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef struct packed {
        logic [2:0]        aluctrl;
        logic              alusrc;
        logic              memwrite;
        logic              regwrite;
        logic [1:0]        wsel;
        logic [REG_AW-1:0] a3;
        logic [REG_AW-1:0] rs;    // 0 when the instruction does not read rs
        logic [REG_AW-1:0] rt;    // 0 when the instruction does not read rt
        logic [1:0]        tnew;
    } ctrl_t;

    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [REG_AW-1:0] w_rs_f;
    logic [REG_AW-1:0] w_rt_f;
    logic [REG_AW-1:0] w_rd_f;
    logic              w_use_rs;
    logic              w_use_rt;
    logic [1:0]        w_tuse_rs;
    logic [1:0]        w_tuse_rt;
    logic [1:0]        w_branch;
    logic [1:0]        w_extop;
    ctrl_t             w_ctrl_d;
    logic              w_hz_rs;
    logic              w_hz_rt;
    logic              w_unused_instr;

    ctrl_t             r_e;
    logic              r_memwrite_m;
    logic              r_regwrite_m;
    logic [1:0]        r_wsel_m;
    logic [REG_AW-1:0] r_a3_m;
    logic [REG_AW-1:0] r_rt_m;
    logic [1:0]        r_tnew_m;
    logic              r_regwrite_w;
    logic [1:0]        r_wsel_w;
    logic [REG_AW-1:0] r_a3_w;

    assign w_op    = instr_d[31:26];
    assign w_funct = instr_d[5:0];
    assign w_rs_f  = instr_d[21 +: REG_AW];
    assign w_rt_f  = instr_d[16 +: REG_AW];
    assign w_rd_f  = instr_d[11 +: REG_AW];
    // Shamt/immediate bits are datapath-only; collected here so lint sees them consumed.
    assign w_unused_instr = &{1'b0, instr_d};

    // ---------------- D-stage decode ----------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        w_ctrl_d  = '0;
        w_branch  = 2'b00;
        w_extop   = 2'b00;
        w_use_rs  = 1'b0;
        w_use_rt  = 1'b0;
        w_tuse_rs = 2'd0;
        w_tuse_rt = 2'd0;
        unique case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    FN_ADDU, FN_SUBU: begin
                        w_ctrl_d.aluctrl  = (w_funct == FN_SUBU) ? 3'b001 : 3'b000;
                        w_ctrl_d.regwrite = 1'b1;
                        w_ctrl_d.a3       = w_rd_f;
                        w_ctrl_d.tnew     = 2'd1;
                        w_use_rs  = 1'b1;
                        w_use_rt  = 1'b1;
                        w_tuse_rs = 2'd1;
                        w_tuse_rt = 2'd1;
                    end
                    FN_JR: begin
                        w_branch = 2'b11;
                        w_use_rs = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ORI: begin
                w_ctrl_d.aluctrl  = 3'b010;
                w_ctrl_d.alusrc   = 1'b1;
                w_ctrl_d.regwrite = 1'b1;
                w_ctrl_d.a3       = w_rt_f;
                w_ctrl_d.tnew     = 2'd1;
                w_extop   = 2'b01;
                w_use_rs  = 1'b1;
                w_tuse_rs = 2'd1;
            end
            OP_LW: begin
                w_ctrl_d.alusrc   = 1'b1;
                w_ctrl_d.regwrite = 1'b1;
                w_ctrl_d.wsel     = 2'b01;
                w_ctrl_d.a3       = w_rt_f;
                w_ctrl_d.tnew     = 2'd2;
                w_use_rs  = 1'b1;
                w_tuse_rs = 2'd1;
            end
            OP_SW: begin
                w_ctrl_d.alusrc   = 1'b1;
                w_ctrl_d.memwrite = 1'b1;
                w_use_rs  = 1'b1;
                w_use_rt  = 1'b1;
                w_tuse_rs = 2'd1;
                w_tuse_rt = 2'd2;
            end
            OP_BEQ: begin
                w_branch = 2'b01;
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
            end
            OP_LUI: begin
                w_ctrl_d.alusrc   = 1'b1;
                w_ctrl_d.regwrite = 1'b1;
                w_ctrl_d.wsel     = 2'b11;
                w_ctrl_d.a3       = w_rt_f;
                w_ctrl_d.tnew     = 2'd1;
                w_extop = 2'b10;
            end
            OP_JAL: begin
                w_branch          = 2'b10;
                w_ctrl_d.regwrite = 1'b1;
                w_ctrl_d.wsel     = 2'b10;
                w_ctrl_d.a3       = REG_AW'(LINK_REG);
            end
            OP_J:    w_branch = 2'b10;
            default: ;
        endcase
        // Unused source fields are zeroed so they can never stall or forward.
        w_ctrl_d.rs = w_use_rs ? w_rs_f : '0;
        w_ctrl_d.rt = w_use_rt ? w_rt_f : '0;
    end

    // ---------------- Hazard detection ----------------
    function automatic logic src_hazard(
        input logic [REG_AW-1:0] src,
        input logic [1:0]        tuse,
        input ctrl_t             e,
        input logic [REG_AW-1:0] a3_mq,
        input logic [1:0]        tnew_mq
    );
        return (src != '0) &&
               (((src == e.a3) && (tuse < e.tnew)) ||
                ((src == a3_mq) && (tuse < tnew_mq)));
    endfunction

    assign w_hz_rs = src_hazard(w_ctrl_d.rs, w_tuse_rs, r_e, r_a3_m, r_tnew_m);
    assign w_hz_rt = src_hazard(w_ctrl_d.rt, w_tuse_rt, r_e, r_a3_m, r_tnew_m);
    assign stall   = HAZARD_EN && (w_hz_rs || w_hz_rt);

    // ---------------- Forwarding selects ----------------
    // Only jal produces its result (PC+8) while still in E.
    function automatic logic [1:0] fwd_sel_d(
        input logic [REG_AW-1:0] src,
        input ctrl_t             e,
        input logic [REG_AW-1:0] a3_mq,
        input logic [1:0]        tnew_mq,
        input logic [REG_AW-1:0] a3_wq
    );
        if (src == '0)                                                  return 2'b00;
        else if ((src == e.a3) && (e.tnew == 2'd0) && (e.wsel == 2'b10)) return 2'b01;
        else if ((src == a3_mq) && (tnew_mq == 2'd0))                   return 2'b10;
        else if (src == a3_wq)                                          return 2'b11;
        else                                                            return 2'b00;
    endfunction

    function automatic logic [1:0] fwd_sel_e(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] a3_mq,
        input logic [1:0]        tnew_mq,
        input logic [REG_AW-1:0] a3_wq
    );
        if (src == '0)                                return 2'b00;
        else if ((src == a3_mq) && (tnew_mq == 2'd0)) return 2'b10;
        else if (src == a3_wq)                        return 2'b11;
        else                                          return 2'b00;
    endfunction

    assign fwd_rs_d = fwd_sel_d(w_ctrl_d.rs, r_e, r_a3_m, r_tnew_m, r_a3_w);
    assign fwd_rt_d = fwd_sel_d(w_ctrl_d.rt, r_e, r_a3_m, r_tnew_m, r_a3_w);
    assign fwd_rs_e = fwd_sel_e(r_e.rs, r_a3_m, r_tnew_m, r_a3_w);
    assign fwd_rt_e = fwd_sel_e(r_e.rt, r_a3_m, r_tnew_m, r_a3_w);
    assign fwd_rt_m = (r_rt_m != '0) && (r_rt_m == r_a3_w);

    // ---------------- Control pipeline registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_e          <= '0;
            r_memwrite_m <= 1'b0;
            r_regwrite_m <= 1'b0;
            r_wsel_m     <= 2'b00;
            r_a3_m       <= '0;
            r_rt_m       <= '0;
            r_tnew_m     <= 2'd0;
            r_regwrite_w <= 1'b0;
            r_wsel_w     <= 2'b00;
            r_a3_w       <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples the previous cycle's values.
            r_e          <= stall ? '0 : w_ctrl_d;
            r_memwrite_m <= r_e.memwrite;
            r_regwrite_m <= r_e.regwrite;
            r_wsel_m     <= r_e.wsel;
            r_a3_m       <= r_e.a3;
            r_rt_m       <= r_e.rt;
            r_tnew_m     <= (r_e.tnew == 2'd0) ? 2'd0 : r_e.tnew - 2'd1;
            r_regwrite_w <= r_regwrite_m;
            r_wsel_w     <= r_wsel_m;
            r_a3_w       <= r_a3_m;
        end
    end

    assign branch_d   = w_branch;
    assign extop_d    = w_extop;
    assign aluctrl_e  = r_e.aluctrl;
    assign alusrc_e   = r_e.alusrc;
    assign a3_e       = r_e.a3;
    assign memwrite_m = r_memwrite_m;
    assign a3_m       = r_a3_m;
    assign regwrite_w = r_regwrite_w;
    assign wsel_w     = r_wsel_w;
    assign a3_w       = r_a3_w;

endmodule

// File: tb/tb_pipe_control.sv
// ---------------------------------------------------------------------------
// tb_pipe_control - self-checking bench for pipe_control.
// An instruction-level model (which instruction sits in which stage) predicts
// every output each cycle; directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_pipe_control;

    localparam int REG_AW    = 5;
    localparam int LINK_REG  = 31;
    localparam bit HAZARD_EN = 1'b1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [31:0]       instr_d;
    logic              stall;
    logic [1:0]        branch_d, extop_d;
    logic [2:0]        aluctrl_e;
    logic              alusrc_e, memwrite_m, regwrite_w;
    logic [1:0]        wsel_w;
    logic [REG_AW-1:0] a3_e, a3_m, a3_w;
    logic [1:0]        fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic              fwd_rt_m;

    pipe_control #(.REG_AW(REG_AW), .LINK_REG(LINK_REG), .HAZARD_EN(HAZARD_EN)) dut (
        .clk(clk), .reset_n(reset_n), .instr_d(instr_d), .stall(stall),
        .branch_d(branch_d), .extop_d(extop_d), .aluctrl_e(aluctrl_e),
        .alusrc_e(alusrc_e), .memwrite_m(memwrite_m), .regwrite_w(regwrite_w),
        .wsel_w(wsel_w), .a3_e(a3_e), .a3_m(a3_m), .a3_w(a3_w),
        .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e),
        .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- Instruction-level model ----------------
    typedef enum logic [3:0] {
        M_NONE, M_ADDU, M_SUBU, M_JR, M_ORI, M_LW, M_SW, M_BEQ, M_LUI, M_JAL, M_J
    } mop_e;

    typedef struct packed {
        mop_e       op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } minst_t;

    minst_t m_e, m_m, m_w;   // instruction occupying E, M, W

    function automatic minst_t m_decode(input logic [31:0] ins);
        minst_t r;
        r.rs = ins[25:21];
        r.rt = ins[20:16];
        r.rd = ins[15:11];
        r.op = M_NONE;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                       6'h21:   r.op = M_ADDU;
                       6'h23:   r.op = M_SUBU;
                       6'h08:   r.op = M_JR;
                       default: r.op = M_NONE;
                   endcase
            6'h0d:   r.op = M_ORI;
            6'h23:   r.op = M_LW;
            6'h2b:   r.op = M_SW;
            6'h04:   r.op = M_BEQ;
            6'h0f:   r.op = M_LUI;
            6'h03:   r.op = M_JAL;
            6'h02:   r.op = M_J;
            default: r.op = M_NONE;
        endcase
        return r;
    endfunction

    function automatic int m_dest(input minst_t i);
        case (i.op)
            M_ADDU, M_SUBU:      return int'(i.rd);
            M_ORI, M_LW, M_LUI:  return int'(i.rt);
            M_JAL:               return LINK_REG;
            default:             return 0;
        endcase
    endfunction

    function automatic int m_src_rs(input minst_t i);
        case (i.op)
            M_ADDU, M_SUBU, M_JR, M_ORI, M_LW, M_SW, M_BEQ: return int'(i.rs);
            default: return 0;
        endcase
    endfunction

    function automatic int m_src_rt(input minst_t i);
        case (i.op)
            M_ADDU, M_SUBU, M_BEQ, M_SW: return int'(i.rt);
            default: return 0;
        endcase
    endfunction

    function automatic int m_tuse_rs(input mop_e op);
        return (op == M_BEQ || op == M_JR) ? 0 : 1;
    endfunction

    function automatic int m_tuse_rt(input mop_e op);
        if (op == M_BEQ) return 0;
        if (op == M_SW)  return 2;
        return 1;
    endfunction

    // Cycles until the result exists, k stages after entering E.
    function automatic int m_tnew(input mop_e op, input int k);
        int t;
        case (op)
            M_LW:                           t = 2;
            M_ADDU, M_SUBU, M_ORI, M_LUI:   t = 1;
            default:                        t = 0;
        endcase
        return (t - k > 0) ? t - k : 0;
    endfunction

    function automatic bit m_src_stalls(input int s, input int tu);
        if (s == 0) return 1'b0;
        return (s == m_dest(m_e) && tu < m_tnew(m_e.op, 0)) ||
               (s == m_dest(m_m) && tu < m_tnew(m_m.op, 1));
    endfunction

    function automatic bit m_stall();
        minst_t d;
        d = m_decode(instr_d);
        return HAZARD_EN && (m_src_stalls(m_src_rs(d), m_tuse_rs(d.op)) ||
                             m_src_stalls(m_src_rt(d), m_tuse_rt(d.op)));
    endfunction

    function automatic int m_fwd_d(input int s);
        if (s == 0) return 0;
        if (s == m_dest(m_e) && m_tnew(m_e.op, 0) == 0 && m_e.op == M_JAL) return 1;
        if (s == m_dest(m_m) && m_tnew(m_m.op, 1) == 0) return 2;
        if (s == m_dest(m_w)) return 3;
        return 0;
    endfunction

    function automatic int m_fwd_e(input int s);
        if (s == 0) return 0;
        if (s == m_dest(m_m) && m_tnew(m_m.op, 1) == 0) return 2;
        if (s == m_dest(m_w)) return 3;
        return 0;
    endfunction

    function automatic int m_branch(input mop_e op);
        case (op)
            M_BEQ:      return 1;
            M_J, M_JAL: return 2;
            M_JR:       return 3;
            default:    return 0;
        endcase
    endfunction

    function automatic int m_extop(input mop_e op);
        return (op == M_ORI) ? 1 : (op == M_LUI) ? 2 : 0;
    endfunction

    function automatic int m_alu(input mop_e op);
        return (op == M_SUBU) ? 1 : (op == M_ORI) ? 2 : 0;
    endfunction

    function automatic bit m_alusrc(input mop_e op);
        return op == M_ORI || op == M_LW || op == M_SW || op == M_LUI;
    endfunction

    function automatic bit m_writes(input mop_e op);
        return op == M_ADDU || op == M_SUBU || op == M_ORI ||
               op == M_LW || op == M_LUI || op == M_JAL;
    endfunction

    function automatic int m_wsel(input mop_e op);
        return (op == M_LW) ? 1 : (op == M_JAL) ? 2 : (op == M_LUI) ? 3 : 0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_e <= '0;
            m_m <= '0;
            m_w <= '0;
        end else begin
            m_w <= m_m;
            m_m <= m_e;
            m_e <= m_stall() ? minst_t'('0) : m_decode(instr_d);
        end
    end

    // ---------------- Per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            check("stall",      stall,      m_stall());
            check("branch_d",   branch_d,   m_branch(m_decode(instr_d).op));
            check("extop_d",    extop_d,    m_extop(m_decode(instr_d).op));
            check("aluctrl_e",  aluctrl_e,  m_alu(m_e.op));
            check("alusrc_e",   alusrc_e,   m_alusrc(m_e.op));
            check("memwrite_m", memwrite_m, m_m.op == M_SW);
            check("regwrite_w", regwrite_w, m_writes(m_w.op));
            check("wsel_w",     wsel_w,     m_wsel(m_w.op));
            check("a3_e",       a3_e,       m_dest(m_e));
            check("a3_m",       a3_m,       m_dest(m_m));
            check("a3_w",       a3_w,       m_dest(m_w));
            check("fwd_rs_d",   fwd_rs_d,   m_fwd_d(m_src_rs(m_decode(instr_d))));
            check("fwd_rt_d",   fwd_rt_d,   m_fwd_d(m_src_rt(m_decode(instr_d))));
            check("fwd_rs_e",   fwd_rs_e,   m_fwd_e(m_src_rs(m_e)));
            check("fwd_rt_e",   fwd_rt_e,   m_fwd_e(m_src_rt(m_e)));
            check("fwd_rt_m",   fwd_rt_m,   m_src_rt(m_m) != 0 && m_src_rt(m_m) == m_dest(m_w));
        end
    end

    // ---------------- Stimulus helpers ----------------
    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [4:0] rreg();
        case ($urandom_range(0, 5))
            0:       return 5'd0;
            1:       return 5'd1;
            2:       return 5'd2;
            3:       return 5'd3;
            4:       return 5'd31;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [15:0] imm;
        logic [25:0] tgt;
        imm = 16'($urandom);
        tgt = 26'($urandom);
        case ($urandom_range(0, 11))
            0:       return r_type(rreg(), rreg(), rreg(), 6'h21);
            1:       return r_type(rreg(), rreg(), rreg(), 6'h23);
            2:       return r_type(rreg(), 5'd0, 5'd0, 6'h08);
            3:       return i_type(6'h0d, rreg(), rreg(), imm);
            4:       return i_type(6'h23, rreg(), rreg(), imm);
            5:       return i_type(6'h2b, rreg(), rreg(), imm);
            6:       return i_type(6'h04, rreg(), rreg(), imm);
            7:       return i_type(6'h0f, 5'd0, rreg(), imm);
            8:       return {6'h03, tgt};
            9:       return {6'h02, tgt};
            10:      return 32'h0000_0000;
            default: return i_type(6'h08, rreg(), rreg(), imm);   // addi: unsupported
        endcase
    endfunction

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic flush(input int n);
        instr_d = 32'h0;
        for (int i = 0; i < n; i++) next_edge();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"},   stall,      0);
        check({tag, "_aluctrl"}, aluctrl_e,  0);
        check({tag, "_alusrc"},  alusrc_e,   0);
        check({tag, "_memwr"},   memwrite_m, 0);
        check({tag, "_regwr"},   regwrite_w, 0);
        check({tag, "_wsel"},    wsel_w,     0);
        check({tag, "_a3"},      {a3_e, a3_m, a3_w}, 0);
        check({tag, "_fwd"},     {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}, 0);
    endtask

    localparam logic [31:0] NOP = 32'h0;

    initial begin
        logic [31:0] lw1, beq12, held_ins;
        bit held;
        reset_n = 1'b0;
        instr_d = NOP;
        #1;
        check_all_zero("reset");
        #11 reset_n = 1'b1;
        next_edge();

        lw1   = i_type(6'h23, 5'd0, 5'd1, 16'd0);
        beq12 = i_type(6'h04, 5'd1, 5'd2, 16'd4);

        // lw $1; addu $2,$1,$3 : one stall, then W->E forward
        instr_d = lw1;                                at_neg(); check("t1_lw", stall, 0); next_edge();
        instr_d = r_type(5'd1, 5'd3, 5'd2, 6'h21);    at_neg(); check("t1_stall", stall, 1); next_edge();
        at_neg(); check("t1_release", stall, 0); next_edge();
        instr_d = NOP; at_neg();
        check("t1_fwd_rs_e", fwd_rs_e, 2'b11);
        check("t1_fwd_rt_e", fwd_rt_e, 2'b00);
        check("t1_a3_e", a3_e, 2);
        flush(3);

        // lw $1; beq $1,$2 : two stalls, then W->D forward
        instr_d = lw1;   at_neg(); check("t2_lw", stall, 0); next_edge();
        instr_d = beq12; at_neg(); check("t2_stall1", stall, 1); next_edge();
        at_neg(); check("t2_stall2", stall, 1); next_edge();
        at_neg();
        check("t2_release", stall, 0);
        check("t2_fwd_rs_d", fwd_rs_d, 2'b11);
        check("t2_fwd_rt_d", fwd_rt_d, 2'b00);
        next_edge();
        flush(3);

        // addu $4,$5,$6; beq $4,$4 : one stall, then M->D forward on both
        instr_d = r_type(5'd5, 5'd6, 5'd4, 6'h21); at_neg(); next_edge();
        instr_d = i_type(6'h04, 5'd4, 5'd4, 16'd1); at_neg(); check("t3_stall", stall, 1); next_edge();
        at_neg();
        check("t3_release", stall, 0);
        check("t3_fwd_rs_d", fwd_rs_d, 2'b10);
        check("t3_fwd_rt_d", fwd_rt_d, 2'b10);
        next_edge();
        flush(3);

        // jal; jr $31 : no stall, PC+8 forwarded from E
        instr_d = {6'h03, 26'h40}; at_neg(); check("t4_jal_branch", branch_d, 2'b10); next_edge();
        instr_d = r_type(5'd31, 5'd0, 5'd0, 6'h08); at_neg();
        check("t4_stall", stall, 0);
        check("t4_fwd_rs_d", fwd_rs_d, 2'b01);
        check("t4_a3_e", a3_e, 31);
        next_edge();
        instr_d = NOP; at_neg(); check("t4_a3_m", a3_m, 31); next_edge();
        at_neg();
        check("t4_wsel_w", wsel_w, 2'b10);
        check("t4_regwrite_w", regwrite_w, 1);
        check("t4_a3_w", a3_w, 31);
        flush(3);

        // ori $0,$0,5; addu $7,$0,$0 : $0 never stalls nor forwards
        instr_d = i_type(6'h0d, 5'd0, 5'd0, 16'd5); at_neg(); next_edge();
        instr_d = r_type(5'd0, 5'd0, 5'd7, 6'h21); at_neg();
        check("t5_stall", stall, 0);
        check("t5_fwd_d", {fwd_rs_d, fwd_rt_d}, 0);
        next_edge();
        instr_d = NOP; at_neg();
        check("t5_fwd_e", {fwd_rs_e, fwd_rt_e}, 0);
        check("t5_a3_e", a3_e, 7);
        next_edge();
        at_neg();
        check("t5_regwrite_w", regwrite_w, 1);
        check("t5_a3_w", a3_w, 0);
        check("t5_fwd_rt_m", fwd_rt_m, 0);
        flush(3);

        // reset asserted in the middle of the lw/beq stall
        instr_d = lw1;   at_neg(); next_edge();
        instr_d = beq12; at_neg(); check("t6_stall", stall, 1);
        reset_n = 1'b0;
        #1;
        check_all_zero("t6_rst");
        #2 reset_n = 1'b1;
        next_edge();
        at_neg(); check("t6_after_release", stall, 0); next_edge();
        flush(3);

        // randomized traffic; IF/ID holds while the model says stall
        held = 1'b0;
        held_ins = NOP;
        for (int c = 0; c < 2500; c++) begin
            if (!held) held_ins = rand_instr();
            instr_d = held_ins;
            at_neg();
            held = m_stall();
            next_edge();
        end
        flush(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
